// File: rtl/footstep_seq_if.sv
// ---------------------------------------------------------------------------
// footstep_seq_if
//   Control/status bundle between the footstep sequencer and its client.
//   The master drives the beat tick, walk control pulses and walk
//   configuration. The slave (the sequencer) returns the two channel tones
//   and the walk status.
//
//   Signals
//     beat_tick  m->s  1      one-cycle pulse per beat
//     start      m->s  1      one-cycle pulse: begin a walk
//     stop       m->s  1      one-cycle pulse: abort a walk
//     num_steps  m->s  CNT_W  footfalls per walk (0 = until stop)
//     lead_left  m->s  1      first footfall on the left channel
//     mono       m->s  1      both channels sound on every footfall
//     toneL      s->m  32     left channel tone
//     toneR      s->m  32     right channel tone
//     busy       s->m  1      walk in progress
//     done       s->m  1      one-cycle pulse: counted walk finished
//     step_cnt   s->m  CNT_W  footfalls completed in the current walk
// ---------------------------------------------------------------------------
interface footstep_seq_if #(
    parameter int CNT_W = 8
);
    logic             beat_tick;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] num_steps;
    logic             lead_left;
    logic             mono;
    logic [31:0]      toneL;
    logic [31:0]      toneR;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        output beat_tick, start, stop, num_steps, lead_left, mono,
        input  toneL, toneR, busy, done, step_cnt
    );

    modport slave (
        input  beat_tick, start, stop, num_steps, lead_left, mono,
        output toneL, toneR, busy, done, step_cnt
    );
endinterface

// File: rtl/footstep_seq.sv
// ---------------------------------------------------------------------------
// footstep_seq
//   Footstep sound sequencer. On each beat tick it walks an alternating
//   right/left footfall pattern: the active foot's channel carries LOW_TONE
//   for STEP_BEATS beats, optionally followed by GAP_BEATS silent beats,
//   then the other foot sounds. Mono mode sounds both channels on every
//   footfall. A walk either counts num_steps footfalls and pulses done, or
//   (num_steps = 0) runs until stop.
//
//   Ports
//     clk   in   1   system clock
//     rst   in   1   asynchronous reset, active-high
//     bus   slave    footstep_seq_if (tick, start/stop, config, tones, status)
// ---------------------------------------------------------------------------
module footstep_seq #(
    parameter int          STEP_BEATS = 4,
    parameter int          GAP_BEATS  = 0,
    parameter logic [31:0] LOW_TONE   = 32'd10,
    parameter logic [31:0] SIL_TONE   = 32'd50000000,
    parameter int          CNT_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    footstep_seq_if.slave  bus
);

    // Beat counter must hold the last index of the longer phase.
    localparam int BEAT_MAX = (STEP_BEATS > GAP_BEATS) ? STEP_BEATS : GAP_BEATS;
    localparam int BEAT_W   = (BEAT_MAX > 1) ? $clog2(BEAT_MAX) : 1;

    localparam logic [BEAT_W-1:0] STEP_LAST = BEAT_W'(STEP_BEATS - 1);
    localparam logic [BEAT_W-1:0] GAP_LAST  = BEAT_W'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_foot;       // 0 = right, 1 = left
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [CNT_W-1:0]   r_num_steps;
    logic               r_mono;
    logic               r_done;
    logic [31:0]        r_toneL;
    logic [31:0]        r_toneR;

    state_t             w_state_nxt;
    logic               w_foot_nxt;
    logic [BEAT_W-1:0]  w_beat_nxt;
    logic [CNT_W-1:0]   w_step_nxt;
    logic [CNT_W-1:0]   w_num_nxt;
    logic               w_mono_nxt;
    logic               w_done_nxt;
    logic [CNT_W:0]     w_step_plus1;
    logic [31:0]        w_toneL_nxt;
    logic [31:0]        w_toneR_nxt;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the combinational block below uses
    // blocking assignments because it is evaluated top to bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_foot      <= 1'b0;
            r_beat_cnt  <= '0;
            r_step_cnt  <= '0;
            r_num_steps <= '0;
            r_mono      <= 1'b0;
            r_done      <= 1'b0;
            r_toneL     <= SIL_TONE;
            r_toneR     <= SIL_TONE;
        end else begin
            r_state     <= w_state_nxt;
            r_foot      <= w_foot_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_step_cnt  <= w_step_nxt;
            r_num_steps <= w_num_nxt;
            r_mono      <= w_mono_nxt;
            r_done      <= w_done_nxt;
            r_toneL     <= w_toneL_nxt;
            r_toneR     <= w_toneR_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_foot_nxt   = r_foot;
        w_beat_nxt   = r_beat_cnt;
        w_step_nxt   = r_step_cnt;
        w_num_nxt    = r_num_steps;
        w_mono_nxt   = r_mono;
        w_done_nxt   = 1'b0;
        w_step_plus1 = {1'b0, r_step_cnt} + (CNT_W + 1)'(1);

        case (r_state)
            S_IDLE: begin
                // A beat tick in the start cycle is deliberately not counted.
                if (bus.start && !bus.stop) begin
                    w_state_nxt = S_STEP;
                    w_foot_nxt  = bus.lead_left;
                    w_beat_nxt  = '0;
                    w_step_nxt  = '0;
                    w_num_nxt   = bus.num_steps;
                    w_mono_nxt  = bus.mono;
                end
            end

            S_STEP: begin
                // stop wins over a coinciding footfall boundary; step_cnt holds.
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.beat_tick) begin
                    if (r_beat_cnt == STEP_LAST) begin
                        w_beat_nxt = '0;
                        if (r_step_cnt != '1) begin
                            w_step_nxt = w_step_plus1[CNT_W-1:0];
                        end
                        if ((r_num_steps != '0) && (w_step_plus1 == {1'b0, r_num_steps})) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end else if (GAP_BEATS > 0) begin
                            w_state_nxt = S_GAP;
                        end else begin
                            w_foot_nxt = ~r_foot;
                        end
                    end else begin
                        w_beat_nxt = r_beat_cnt + BEAT_W'(1);
                    end
                end
            end

            S_GAP: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.beat_tick) begin
                    if (r_beat_cnt == GAP_LAST) begin
                        w_state_nxt = S_STEP;
                        w_foot_nxt  = ~r_foot;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat_cnt + BEAT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Tones are decoded from the next state so they change on the same
        // edge as the state register.
        w_toneL_nxt = SIL_TONE;
        w_toneR_nxt = SIL_TONE;
        if (w_state_nxt == S_STEP) begin
            if (w_mono_nxt || w_foot_nxt) begin
                w_toneL_nxt = LOW_TONE;
            end
            if (w_mono_nxt || !w_foot_nxt) begin
                w_toneR_nxt = LOW_TONE;
            end
        end
    end

    assign bus.toneL    = r_toneL;
    assign bus.toneR    = r_toneR;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.step_cnt = r_step_cnt;

endmodule
